// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   state_t : controller FSM state (OFF, RUN, PEND)
//   DIV_MIN : smallest divisor the core can produce a 50 % duty clock for
package clk_div_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: integer divider datapath producing a 50 % duty clock.
//   clk, rst : source clock, async active-high reset
//   div      : divisor N in effect (only changes on a wrap edge)
//   run      : 0 holds the counter and output low
//   load     : restart from count 0 with the output low
//   clk_out  : divided clock (odd N ANDs posedge and negedge copies)
//   wrap     : high during the last cycle of an output period
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  input  logic             load,
  output logic             clk_out,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;
  logic             p_reg;
  logic             n_reg;
  logic [DIV_W:0]   div_x;
  logic [DIV_W:0]   half;
  logic [DIV_W:0]   last;

  // One extra bit so ceil(N/2) stays exact at N = 2^DIV_W - 1.
  assign div_x = {1'b0, div};
  assign half  = (div_x + (DIV_W+1)'(1)) >> 1;
  assign last  = div_x - (DIV_W+1)'(1);
  // >= rather than == so a stray count above N-1 still wraps.
  assign wrap  = run && ({1'b0, cnt} >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      p_reg <= 1'b0;
    end else if (!run || load) begin
      cnt   <= '0;
      p_reg <= 1'b0;
    end else begin
      p_reg <= ({1'b0, cnt} < half);
      cnt   <= wrap ? '0 : cnt + DIV_W'(1);
    end
  end

  // Half-cycle delayed copy; ANDing trims the high phase by half a cycle
  // so odd ratios come out at exactly N/2 periods high.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) n_reg <= 1'b0;
    else     n_reg <= p_reg;
  end

  // p_reg is low right after every wrap, so swapping the mode bit there
  // cannot create a glitch.
  assign clk_out = div[0] ? (p_reg & n_reg) : p_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a request controller.
//   clk, rst  : source clock, async active-high reset
//   cfg_valid : request valid; cfg_ready : request can be accepted
//   cfg_div   : requested divisor; cfg_en : 1 run, 0 stop
//   clk_out   : divided clock
//   div_cur   : divisor in effect
//   busy      : a request is waiting for the period boundary
//   err       : one-cycle pulse for a rejected divisor (< 2 with cfg_en)
// Requests taken while running wait for the next period boundary so the
// output never shows a shortened pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             clk_out,
  output logic [DIV_W-1:0] div_cur,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic [DIV_W-1:0] pend_div;
  logic             pend_en;
  logic             accept;
  logic             bad;
  logic             run;
  logic             load;
  logic             wrap;

  assign cfg_ready = (state != PEND);
  assign busy      = (state == PEND);
  assign accept    = cfg_valid & cfg_ready;
  assign bad       = cfg_en && ({1'b0, cfg_div} < (DIV_W+1)'(DIV_MIN));
  assign run       = (state != OFF);
  assign load      = (state == OFF) && accept && cfg_en && !bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      div_cur  <= DIV_W'(DIV_RST);
      pend_div <= '0;
      pend_en  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept && bad;
      unique case (state)
        OFF: begin
          // Stop requests while stopped are no-ops.
          if (load) begin
            div_cur <= cfg_div;
            state   <= RUN;
          end
        end
        RUN: begin
          // Even when accepted on a wrap edge, the request waits a full
          // period: applying it here would cut the period in progress.
          if (accept && !bad) begin
            pend_div <= cfg_div;
            pend_en  <= cfg_en;
            state    <= PEND;
          end
        end
        PEND: begin
          if (wrap) begin
            if (pend_en) begin
              div_cur <= pend_div;
              state   <= RUN;
            end else begin
              state   <= OFF;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .div     (div_cur),
    .run     (run),
    .load    (load),
    .clk_out (clk_out),
    .wrap    (wrap)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl. Each expected clk_out
// pulse (high time, rise-to-rise period, divisor at the rise) is queued by
// the stimulus; a monitor measures every pulse and compares it against the
// queue. Time unit: clk period = 10.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       clk_out;
  logic [7:0] div_cur;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W   (8),
    .DIV_RST (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .clk_out   (clk_out),
    .div_cur   (div_cur),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    int high;
    int per;   // 0: previous rise is not meaningful, skip period check
    int div;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int h, input int p, input int d);
    exp_q.push_back(exp_t'{high: h, per: p, div: d});
  endtask

  // ---------------- monitor ----------------
  int   rise_t    = 0;
  int   last_rise = 0;
  int   per_meas  = 0;
  int   rise_div  = 0;
  int   high_meas = 0;
  bit   have_rise = 1'b0;
  bit   in_pulse  = 1'b0;
  exp_t e;

  always @(clk_out) begin
    if (clk_out === 1'b1 && !in_pulse) begin
      in_pulse  = 1'b1;
      rise_t    = int'($time);
      per_meas  = have_rise ? rise_t - last_rise : 0;
      last_rise = rise_t;
      have_rise = 1'b1;
      rise_div  = int'(div_cur);
    end else if (clk_out === 1'b0 && in_pulse) begin
      in_pulse  = 1'b0;
      high_meas = int'($time) - rise_t;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: high %0d at t=%0t, none expected", high_meas, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_high", high_meas, e.high);
        if (e.per != 0) chk("pulse_period", per_meas, e.per);
        chk("pulse_div", rise_div, e.div);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d pulses outstanding after %0d cycles", exp_q.size(), max_cyc);
      exp_q.delete();
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic en, input logic [7:0] d);
    int n = 0;
    cfg_en    = en;
    cfg_div   = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: cfg_ready %0d, expected 1", cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int hi_seen;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_en    = 1'b0;
    cfg_div   = 8'd0;
    #2 rst = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_div_cur", div_cur, 9);

    // Free-running at N=9 from release: high 45, period 90
    push(45, 0, 9);
    push(45, 90, 9);
    push(45, 90, 9);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(200);

    // N=1 is rejected; output undisturbed
    send(1'b1, 8'd1);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_ready", cfg_ready, 1);
    chk("err_div_cur", div_cur, 9);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    push(45, 90, 9);
    push(45, 90, 9);
    wait_drain(200);

    // N=4 requested three cycles before the boundary
    send(1'b1, 8'd4);
    chk("n4_busy", busy, 1);
    chk("n4_ready", cfg_ready, 0);
    chk("n4_div_old", div_cur, 9);
    push(20, 85, 4);
    push(20, 40, 4);
    push(20, 40, 4);
    @(negedge clk);
    chk("n4_busy_hold", busy, 1);
    @(negedge clk);
    chk("n4_applied_busy", busy, 0);
    chk("n4_applied_div", div_cur, 4);
    wait_drain(200);

    // Stop accepted on a boundary edge: one more full period, then low
    send(1'b0, 8'd0);
    chk("stop_busy", busy, 1);
    push(20, 40, 4);
    wait_drain(100);
    @(negedge clk);
    chk("off_busy", busy, 0);
    hi_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (clk_out) hi_seen++;
    end
    chk("off_clk_low", hi_seen, 0);
    chk("off_ready", cfg_ready, 1);
    chk("off_div_hold", div_cur, 4);

    // Start from OFF at N=3: high 15, period 30
    push(15, 0, 3);
    push(15, 30, 3);
    push(15, 30, 3);
    send(1'b1, 8'd3);
    chk("n3_div", div_cur, 3);
    chk("n3_busy", busy, 0);
    wait_drain(100);

    // N=6 then N=5 with cfg_valid held: second stalls during PEND
    push(15, 30, 3);
    push(30, 25, 6);
    push(25, 65, 5);
    push(25, 50, 5);
    cfg_en    = 1'b1;
    cfg_div   = 8'd6;
    cfg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_div = 8'd5;
    chk("b2b_busy", busy, 1);
    chk("b2b_stall0", cfg_ready, 0);
    @(negedge clk);
    chk("b2b_stall1", cfg_ready, 0);
    @(negedge clk);
    chk("b2b_ready_after_apply", cfg_ready, 1);
    chk("b2b_div6", div_cur, 6);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("b2b_second_pending", busy, 1);
    chk("b2b_div_still6", div_cur, 6);
    wait_drain(200);

    // Reset while clk_out is high in PEND: pending N=4 is dropped
    push(11, 50, 5);
    push(45, 0, 9);
    push(45, 90, 9);
    push(45, 90, 9);
    send(1'b1, 8'd4);
    chk("rstp_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstp_clk_high", clk_out, 1);
    chk("rstp_busy_hold", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstp_clk_low", clk_out, 0);
    chk("rstp_busy_clr", busy, 0);
    chk("rstp_ready", cfg_ready, 1);
    chk("rstp_div", div_cur, 9);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(300);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
